// File: rtl/mesh_term_arbiter.sv
// Round-robin injection arbiter sharing one mesh terminal input port among NUM_SRC FIFO-head sources.
// Optional DEST_CHECK_EN: discard heads addressed outside the ROWS x COLUMS mesh, counted in drop_cnt.
module mesh_term_arbiter #(
  parameter int pckg_sz = 40,
  parameter int NUM_SRC = 4,
  parameter int ROWS    = 4,
  parameter int COLUMS  = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_pndng,
  input  logic [NUM_SRC*pckg_sz-1:0] src_data,
  output logic [NUM_SRC-1:0]         src_pop,
  output logic [pckg_sz-1:0]         term_data,
  output logic                       term_pndng,
  input  logic                       term_popin,
  output logic [NUM_SRC-1:0]         grant,
  output logic [CNT_W-1:0]           drop_cnt
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                          state_reg, state_next;
  logic [IDX_W-1:0]                rr_ptr_reg, rr_ptr_next;
  logic [pckg_sz-1:0]              data_reg, data_next;
  logic                            pndng_reg, pndng_next;
  logic [NUM_SRC-1:0]              grant_reg, grant_next;
  logic [NUM_SRC-1:0]              pop_reg, pop_next;
  logic [NUM_SRC-1:0][pckg_sz-1:0] head;
  logic [NUM_SRC-1:0]              eligible, head_ok;
  logic                            win_found;
  logic [IDX_W-1:0]                win_idx, cand;
`ifdef DEST_CHECK_EN
  logic [CNT_W-1:0]                drop_reg, drop_next;
`endif

  assign head = src_data;
  // A source being popped this cycle still shows its old head, so it sits out this edge.
  assign eligible = src_pndng & ~pop_reg;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_dest
`ifdef DEST_CHECK_EN
    logic [3:0] row, col;
    assign row = head[gi][pckg_sz-9 -: 4];
    assign col = head[gi][pckg_sz-13 -: 4];
    assign head_ok[gi] = (row == 4'hF && col == 4'hF) ||
                         (int'(row) < ROWS && int'(col) < COLUMS);
`else
    assign head_ok[gi] = 1'b1;
`endif
  end

  // First eligible source searching upward from the one after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_reg;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IDX_W'((int'(rr_ptr_reg) + k) % NUM_SRC);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    data_next   = data_reg;
    pndng_next  = pndng_reg;
    grant_next  = grant_reg;
    pop_next    = '0;
`ifdef DEST_CHECK_EN
    drop_next   = drop_reg;
`endif
    if (state_reg == OFFER && term_popin) begin
      state_next = IDLE;
      pndng_next = 1'b0;
      grant_next = '0;
    end
    if ((state_reg == IDLE || term_popin) && win_found) begin
      rr_ptr_next = win_idx;
      pop_next    = NUM_SRC'(1) << win_idx;
      if (head_ok[win_idx]) begin
        state_next = OFFER;
        data_next  = head[win_idx];
        pndng_next = 1'b1;
        grant_next = NUM_SRC'(1) << win_idx;
      end
`ifdef DEST_CHECK_EN
      else if (drop_reg != '1) begin
        drop_next = drop_reg + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= IDX_W'(NUM_SRC - 1);
      data_reg   <= '0;
      pndng_reg  <= 1'b0;
      grant_reg  <= '0;
      pop_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      data_reg   <= data_next;
      pndng_reg  <= pndng_next;
      grant_reg  <= grant_next;
      pop_reg    <= pop_next;
    end
  end

`ifdef DEST_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_reg <= '0;
    else        drop_reg <= drop_next;
  end
  assign drop_cnt = drop_reg;
`else
  assign drop_cnt = '0;
`endif

  assign src_pop    = pop_reg;
  assign term_data  = data_reg;
  assign term_pndng = pndng_reg;
  assign grant      = grant_reg;
endmodule
